md_sched: RTL and testbench
===========================

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 The block SHALL provide parameter MUL_LAT, default 5, meaning cycles from mult/multu issue to HI/LO commit.
REQ-002 The block SHALL provide parameter DIV_LAT, default 10, meaning cycles from div/divu issue to HI/LO commit; legal range for both parameters is 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 e_valid  input  1  E-stage holds a real instruction, not a bubble.
REQ-006 e_op  input  4  E-stage MD opcode class, encoded per md_pkg: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-007 irq  input  1  interrupt/exception flushes the E-stage instruction this cycle.
REQ-008 d_uses_md  input  1  D-stage instruction is any of the eight MD ops.
REQ-009 md_start  output  1  one-cycle issue pulse to the multiply/divide datapath.
REQ-010 md_func  output  2  datapath operation: 0 mult, 1 multu, 2 div, 3 divu.
REQ-011 hi_we / lo_we  output  1 each  write HI/LO from rs for mthi/mtlo.
REQ-012 hilo_commit  output  1  one-cycle pulse; the datapath loads its result into HI/LO.
REQ-013 busy  output  1  the unit is issuing or running.
REQ-014 stall_d  output  1  hold the D stage.
REQ-015 cnt  output  4  cycles remaining in the current operation.
REQ-016 bad_issue  output  1  sticky; an MD op reached E while busy.

Function
REQ-017 The FSM SHALL have the states IDLE, MUL_RUN and DIV_RUN.
REQ-018 issue is defined as e_valid & ~irq & state==IDLE & e_op in {MULT, MULTU, DIV, DIVU}.
REQ-019 On issue, md_start SHALL be driven combinationally high in the same cycle, with md_func decoded from e_op.
REQ-020 At the issue edge, the block SHALL load cnt with MUL_LAT or DIV_LAT and enter MUL_RUN or DIV_RUN.
REQ-021 In a RUN state, cnt SHALL decrement by 1 per edge.
REQ-022 hilo_commit SHALL be high exactly while in a RUN state with cnt==1; the following edge returns the FSM to IDLE with cnt=0.
REQ-023 With an issue in cycle T, hilo_commit SHALL be high in cycle T+LAT and busy SHALL be low from cycle T+LAT+1.
REQ-024 busy = md_start | (state != IDLE).
REQ-025 stall_d = d_uses_md & busy.
REQ-026 hi_we/lo_we SHALL assert only when e_valid & ~irq & ~busy and e_op is MTHI/MTLO respectively.
REQ-027 MFHI/MFLO SHALL produce no output from this block; the stall rule keeps them out of E while busy.
REQ-028 irq in the issue cycle SHALL suppress md_start, hi_we and lo_we, and the FSM SHALL stay in IDLE.
REQ-029 irq while in a RUN state SHALL have no effect; the issued operation completes and commits.
REQ-030 An e_valid MD op (any of the eight) in E while state != IDLE SHALL be ignored (no start, no write) and SHALL set bad_issue until reset.
REQ-031 An issue request in the same cycle as hilo_commit SHALL be ignored and SHALL set bad_issue; back-to-back issue is legal only from IDLE.
REQ-032 e_op NONE, or e_valid=0, SHALL cause no action.

Reset
REQ-033 Asserting reset at any time SHALL immediately force state IDLE, cnt 0 and bad_issue 0; any in-flight operation is abandoned without hilo_commit.
REQ-034 While reset is asserted, md_start, hi_we, lo_we, hilo_commit, busy and stall_d SHALL all be 0.

Structure
REQ-035 md_pkg SHALL hold the e_op encodings, md_func codes, FSM state encodings, and default MUL_LAT/DIV_LAT values.
REQ-036 One sub-module, md_lat_counter, SHALL be used: a 4-bit load/decrement counter with an is_one flag, instantiated once.

Verification
REQ-037 MULT issued in cycle 0 -> md_start=1 and md_func=0 in cycle 0; cnt reads 5,4,3,2,1 in cycles 1-5; hilo_commit=1 in cycle 5 only; busy=0 in cycle 6.
REQ-038 DIVU issued with d_uses_md=1 (MFLO behind it) -> stall_d=1 in cycles 0-10, hilo_commit in cycle 10, stall_d=0 in cycle 11.
REQ-039 DIV with irq=1 in the issue cycle -> md_start=0, busy=0, state IDLE; MTHI with irq=1 -> hi_we=0.
REQ-040 MULTU issued, irq=1 in cycle 3 -> commit still occurs in cycle 5.
REQ-041 DIV issued, reset pulsed in cycle 4 -> cnt=0 and busy=0 immediately; no hilo_commit in cycle 10.
REQ-042 MULT running, forced e_valid MTLO in cycle 2 -> lo_we=0 and bad_issue=1, held until reset.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide scheduler.
//   - E-stage opcode classes (e_op)
//   - datapath function codes (md_func)
//   - FSM state encodings
//   - default multiply/divide latencies
package md_pkg;

   // E-stage MD opcode classes
   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   // datapath operation codes
   localparam logic [1:0] FN_MULT  = 2'd0;
   localparam logic [1:0] FN_MULTU = 2'd1;
   localparam logic [1:0] FN_DIV   = 2'd2;
   localparam logic [1:0] FN_DIVU  = 2'd3;

   // FSM states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MUL_RUN = 2'd1;
   localparam logic [1:0] ST_DIV_RUN = 2'd2;

   // default latencies, issue cycle to HI/LO commit cycle (legal 1..15)
   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;

   // true for the four ops that occupy the multiply/divide datapath
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // true for any of the eight MD ops
   function automatic logic is_mdop(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_MTLO);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: E/D-stage control bundle between the pipeline and md_sched.
//   master : pipeline side, drives e_valid/e_op/irq/d_uses_md
//   slave  : scheduler side, drives issue/commit/write/stall/status outputs
interface md_sched_if;
   logic       e_valid;
   logic [3:0] e_op;
   logic       irq;
   logic       d_uses_md;
   logic       md_start;
   logic [1:0] md_func;
   logic       hi_we;
   logic       lo_we;
   logic       hilo_commit;
   logic       busy;
   logic       stall_d;
   logic [3:0] cnt;
   logic       bad_issue;

   modport master (
      output e_valid, e_op, irq, d_uses_md,
      input  md_start, md_func, hi_we, lo_we, hilo_commit, busy, stall_d, cnt, bad_issue
   );

   modport slave (
      input  e_valid, e_op, irq, d_uses_md,
      output md_start, md_func, hi_we, lo_we, hilo_commit, busy, stall_d, cnt, bad_issue
   );
endinterface

// File: rtl/md_lat_counter.sv
// md_lat_counter: 4-bit load/decrement latency counter.
//   clk, rst   : clock, async active-high reset (clears to 0)
//   load_i     : load load_val_i this edge (wins over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one this edge (saturates at 0)
//   cnt_o      : current count
//   is_one_o   : count equals 1 (last cycle of the operation)
module md_lat_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic [3:0] cnt_o,
   output logic       is_one_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 4'd0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o    = cnt_q;
   assign is_one_o = (cnt_q == 4'd1);

endmodule

// File: rtl/md_sched.sv
// md_sched: issue/commit scheduler for the HI/LO multiply/divide unit.
//   clk   : clock
//   reset : async active-high reset; abandons any in-flight operation
//   bus   : md_sched_if.slave
//           in : e_valid, e_op, irq, d_uses_md
//           out: md_start/md_func (issue pulse), hi_we/lo_we (mthi/mtlo),
//                hilo_commit, busy, stall_d, cnt, bad_issue (sticky)
module md_sched
   import md_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   md_sched_if.slave  bus
);

   logic [1:0] state_q, state_d;
   logic       bad_q, bad_d;
   logic       idle, start, busy_w, is_div, cnt_is_one;
   logic [3:0] lat_sel;

   assign idle   = (state_q == ST_IDLE);
   assign is_div = (bus.e_op == OP_DIV) || (bus.e_op == OP_DIVU);

   // reset gating keeps the issue pulse quiet while reset is held, since the
   // combinational path would otherwise see IDLE and a live opcode
   assign start  = bus.e_valid & ~bus.irq & idle & is_muldiv(bus.e_op) & ~reset;
   assign busy_w = start | ~idle;

   assign lat_sel = is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);

   md_lat_counter u_cnt (
      .clk        (clk),
      .rst        (reset),
      .load_i     (start),
      .load_val_i (lat_sel),
      .dec_i      (~idle),
      .cnt_o      (bus.cnt),
      .is_one_o   (cnt_is_one)
   );

   always_comb begin
      bus.md_func = FN_MULT;
      case (bus.e_op)
         OP_MULTU: bus.md_func = FN_MULTU;
         OP_DIV:   bus.md_func = FN_DIV;
         OP_DIVU:  bus.md_func = FN_DIVU;
         default:  bus.md_func = FN_MULT;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (start)
         state_d = is_div ? ST_DIV_RUN : ST_MUL_RUN;
      else if (!idle && cnt_is_one)
         state_d = ST_IDLE;
   end

   // any MD op reaching E outside IDLE means the hazard logic let something
   // through; this also covers an issue attempt in the commit cycle
   assign bad_d = bad_q | (bus.e_valid & is_mdop(bus.e_op) & ~idle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bad_q   <= bad_d;
      end
   end

   assign bus.md_start    = start;
   assign bus.busy        = busy_w;
   assign bus.stall_d     = bus.d_uses_md & busy_w;
   assign bus.hilo_commit = ~idle & cnt_is_one;
   assign bus.hi_we       = bus.e_valid & ~bus.irq & ~busy_w & (bus.e_op == OP_MTHI) & ~reset;
   assign bus.lo_we       = bus.e_valid & ~bus.irq & ~busy_w & (bus.e_op == OP_MTLO) & ~reset;
   assign bus.bad_issue   = bad_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and randomized checks of md_sched against a
// cycle-number model (issue cycle + latency) kept in the bench.
module tb_md_sched;
   import md_pkg::*;

   localparam int ML = 5;
   localparam int DL = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   md_sched_if bus();

   md_sched #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // model: one operation in flight, issued in cycle m_t with latency m_lat
   int cyc = 0;
   bit m_act = 0;
   int m_t = 0;
   int m_lat = 0;
   bit m_bad = 0;

   // last sampled outputs, for literal checks after a step
   logic       s_start, s_commit, s_busy, s_stall, s_hi, s_lo, s_bad;
   logic [1:0] s_func;
   logic [3:0] s_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [1:0] fn_of(input logic [3:0] op);
      case (op)
         OP_MULTU: return 2'd1;
         OP_DIV:   return 2'd2;
         OP_DIVU:  return 2'd3;
         default:  return 2'd0;
      endcase
   endfunction

   function automatic bit op_muldiv(input logic [3:0] op);
      return op >= 4'd1 && op <= 4'd4;
   endfunction

   task automatic drive(input bit v, input logic [3:0] op, input bit irq, input bit du);
      bus.e_valid   = v;
      bus.e_op      = op;
      bus.irq       = irq;
      bus.d_uses_md = du;
   endtask

   // called just after a rising edge with inputs already driven
   task automatic step();
      bit run, st, cm, bz;
      logic [3:0] ec;
      @(negedge clk);
      run = m_act;
      cm  = run && (cyc == m_t + m_lat);
      ec  = run ? 4'(m_t + m_lat + 1 - cyc) : 4'd0;
      st  = !run && bus.e_valid && !bus.irq && op_muldiv(bus.e_op);
      bz  = st || run;
      chk("md_start", bus.md_start, st);
      if (st) chk("md_func", bus.md_func, fn_of(bus.e_op));
      chk("busy", bus.busy, bz);
      chk("stall_d", bus.stall_d, bus.d_uses_md && bz);
      chk("hilo_commit", bus.hilo_commit, cm);
      chk("cnt", bus.cnt, ec);
      chk("hi_we", bus.hi_we, bus.e_valid && !bus.irq && !bz && bus.e_op == OP_MTHI);
      chk("lo_we", bus.lo_we, bus.e_valid && !bus.irq && !bz && bus.e_op == OP_MTLO);
      chk("bad_issue", bus.bad_issue, m_bad);
      s_start = bus.md_start; s_func = bus.md_func; s_commit = bus.hilo_commit;
      s_busy = bus.busy; s_stall = bus.stall_d; s_hi = bus.hi_we; s_lo = bus.lo_we;
      s_cnt = bus.cnt; s_bad = bus.bad_issue;
      @(posedge clk);
      if (run && bus.e_valid && bus.e_op >= 4'd1 && bus.e_op <= 4'd8) m_bad = 1;
      if (cm) m_act = 0;
      if (st) begin
         m_act = 1;
         m_t   = cyc;
         m_lat = (bus.e_op == OP_DIV || bus.e_op == OP_DIVU) ? DL : ML;
      end
      cyc++;
      #1;
   endtask

   // asynchronous reset mid-cycle with a live issue request on the inputs
   task automatic pulse_reset();
      drive(1, OP_MULT, 0, 1);
      reset = 1'b1;
      #1;
      chk("rst md_start", bus.md_start, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst stall_d", bus.stall_d, 0);
      chk("rst hilo_commit", bus.hilo_commit, 0);
      chk("rst cnt", bus.cnt, 0);
      chk("rst bad_issue", bus.bad_issue, 0);
      drive(1, OP_MTHI, 0, 0);
      #1;
      chk("rst hi_we", bus.hi_we, 0);
      m_act = 0;
      m_bad = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
      drive(0, OP_NONE, 0, 0);
   endtask

   initial begin
      drive(0, OP_NONE, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      // idle with no op
      step();
      chk("idle cnt", s_cnt, 0);

      // MULT: start+func in cycle 0, cnt 5..1, commit in cycle 5, free in 6
      drive(1, OP_MULT, 0, 0);
      step();
      chk("mult start", s_start, 1);
      chk("mult func", s_func, 0);
      drive(0, OP_NONE, 0, 0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("mult cnt", s_cnt, 4'(6 - i));
         chk("mult commit", s_commit, (i == 5));
      end
      step();
      chk("mult busy after", s_busy, 0);

      // DIVU with MFLO waiting in D: stall 0..10, commit 10, release 11
      drive(1, OP_DIVU, 0, 1);
      step();
      chk("divu func", s_func, 3);
      chk("divu stall0", s_stall, 1);
      drive(0, OP_NONE, 0, 1);
      for (int i = 1; i <= 11; i++) begin
         step();
         chk("divu stall", s_stall, (i <= 10));
         chk("divu commit", s_commit, (i == 10));
      end
      drive(0, OP_NONE, 0, 0);

      // irq in issue cycle kills DIV and MTHI
      drive(1, OP_DIV, 1, 0);
      step();
      chk("div irq start", s_start, 0);
      chk("div irq busy", s_busy, 0);
      drive(1, OP_MTHI, 1, 0);
      step();
      chk("div irq stays idle", s_busy, 0);
      chk("mthi irq", s_hi, 0);
      drive(1, OP_MTHI, 0, 0);
      step();
      chk("mthi", s_hi, 1);
      drive(1, OP_MTLO, 0, 0);
      step();
      chk("mtlo", s_lo, 1);
      drive(1, OP_MFHI, 0, 0);
      step();
      drive(0, OP_DIV, 0, 0);
      step();
      chk("no valid no start", s_start, 0);

      // MULTU with irq in cycle 3 still commits in cycle 5
      drive(1, OP_MULTU, 0, 0);
      step();
      chk("multu func", s_func, 1);
      for (int i = 1; i <= 5; i++) begin
         drive(0, OP_NONE, (i == 3), 0);
         step();
         chk("multu irq commit", s_commit, (i == 5));
      end
      drive(0, OP_NONE, 0, 0);

      // DIV abandoned by reset in cycle 4, never commits
      drive(1, OP_DIV, 0, 0);
      step();
      drive(0, OP_NONE, 0, 0);
      repeat (3) step();
      pulse_reset();
      for (int i = 5; i <= 11; i++) begin
         step();
         chk("div abandoned", s_commit, 0);
      end

      // MTLO forced into E while MULT runs: no write, sticky bad_issue
      drive(1, OP_MULT, 0, 0);
      step();
      drive(0, OP_NONE, 0, 0);
      step();
      drive(1, OP_MTLO, 0, 0);
      step();
      chk("mtlo busy lo_we", s_lo, 0);
      drive(0, OP_NONE, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("bad held", s_bad, 1);
      end
      pulse_reset();

      // issue attempt in the commit cycle is ignored
      drive(1, OP_MULT, 0, 0);
      step();
      drive(0, OP_NONE, 0, 0);
      repeat (4) step();
      drive(1, OP_MULTU, 0, 0);
      step();
      chk("commit-cycle commit", s_commit, 1);
      chk("commit-cycle start", s_start, 0);
      drive(0, OP_NONE, 0, 0);
      step();
      chk("commit-cycle bad", s_bad, 1);
      chk("commit-cycle idle", s_busy, 0);
      pulse_reset();

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) pulse_reset();
         drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
         step();
         // keep bad_issue from latching permanently most of the time
         if (m_bad && $urandom_range(0, 3) == 0) pulse_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
